source_controller: RTL and testbench



---
 rtl/ahb_bridge_pkg.sv | 28 ++
 rtl/source_rsp_timer.sv | 47 ++++
 rtl/source_controller.sv | 142 ++++++++++++++
 tb/tb_source_controller.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bridge_pkg.sv
// Shared definitions for the AHB-to-AHB bridge source and sink controllers:
// controller state encoding, packet field offsets and packet width derivation.
package ahb_bridge_pkg;

   typedef enum logic [1:0] {
      StNormal,
      StWaitRsp,
      StDrain,
      StSleep
   } bridge_state_e;

   localparam int unsigned BRIDGE_ADDR_WIDTH = 32;
   localparam int unsigned BRIDGE_DATA_WIDTH = 32;

   // Request packet is {rd0_wr1, valid, addr, wr_data}.
   function automatic int unsigned packet_width(input int unsigned aw, input int unsigned dw);
      return aw + dw + 2;
   endfunction

   localparam int unsigned RD0_WR1_BIT   = packet_width(BRIDGE_ADDR_WIDTH, BRIDGE_DATA_WIDTH) - 1;
   localparam int unsigned VALID_BIT     = RD0_WR1_BIT - 1;
   localparam int unsigned ADDR_LSB      = BRIDGE_DATA_WIDTH;
   localparam int unsigned RSP_VALID_BIT = BRIDGE_DATA_WIDTH;

   // Number of timed-out reads whose late responses may still arrive.
   localparam int unsigned STALE_WIDTH = 4;

endpackage

// File: rtl/source_rsp_timer.sv
// Response timeout counter and stale-response tracker for the bridge source controller.
// Only instantiated when SOURCE_RSP_TIMEOUT_EN is defined.
module source_rsp_timer
   import ahb_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic waiting,
   input  logic rsp_done,
   input  logic stale_drop,
   output logic timeout,
   output logic stale_pending
);

   localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

   logic [CntWidth-1:0]    cnt_q, cnt_d;
   logic [STALE_WIDTH-1:0] stale_q, stale_d;

   assign timeout       = waiting && !rsp_done && (cnt_q == CntLast);
   assign stale_pending = (stale_q != '0);

   always_comb begin
      cnt_d   = (waiting && !rsp_done && !timeout) ? cnt_q + 1'b1 : '0;
      stale_d = stale_q;
      // Saturate rather than wrap so a late response is never completed as a fresh read.
      if (timeout && !(&stale_q)) begin
         stale_d = stale_q + 1'b1;
      end else if (stale_drop) begin
         stale_d = stale_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         stale_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         stale_q <= stale_d;
      end
   end

endmodule

// File: rtl/source_controller.sv
// Source-side controller of the AHB-to-AHB bridge: packs slave transfers into request packets,
// completes reads from the response FIFO and runs the source half of the sleep handshake.
// Optional response timeout with stale-response dropping: define SOURCE_RSP_TIMEOUT_EN.
module source_controller
   import ahb_bridge_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned PACKET_WIDTH   = 66,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                    i_clk_source,
   input  logic                    i_rstn_source,
   input  logic                    i_source_sleep_req,
   input  logic                    sink_sleep_status,
   input  logic                    i_valid,
   input  logic                    i_rd0_wr1,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   input  logic [DATA_WIDTH-1:0]   i_wr_data,
   output logic                    o_ready,
   output logic [DATA_WIDTH-1:0]   o_rd_data,
   output logic                    o_rd_valid,
   output logic                    o_rd_err,
   input  logic                    req_fifo_full,
   input  logic                    req_fifo_empty,
   output logic                    req_fifo_wr_en,
   output logic [PACKET_WIDTH-1:0] o_packet,
   input  logic                    rsp_fifo_empty,
   input  logic [DATA_WIDTH:0]     i_packet,
   output logic                    rsp_fifo_rd_en,
   output logic                    o_source_sleep_ack,
   output logic                    source_sleep_status
);

   localparam int unsigned RdWrBit  = packet_width(ADDR_WIDTH, DATA_WIDTH) - 1;
   localparam int unsigned ValidBit = RdWrBit - 1;

   bridge_state_e         state_q, state_d;
   logic                  rd_valid_q, rd_err_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  sleep_pending, rsp_done, timeout, stale_pending, stale_drop;

   assign sleep_pending = i_source_sleep_req || sink_sleep_status;
   assign rsp_done      = (state_q == StWaitRsp) && !rsp_fifo_empty && i_packet[DATA_WIDTH];

   // Gated by reset so every output reads 0 while reset is held.
   assign o_ready = i_rstn_source && (state_q == StNormal) && !req_fifo_full && !sleep_pending
                    && !rd_valid_q && !stale_pending;
   assign req_fifo_wr_en = i_valid && o_ready;

   always_comb begin
      o_packet = '0;
      if (req_fifo_wr_en) begin
         o_packet[RdWrBit]                 = i_rd0_wr1;
         o_packet[ValidBit]                = 1'b1;
         o_packet[DATA_WIDTH +: ADDR_WIDTH] = i_addr;
         o_packet[DATA_WIDTH-1:0]          = i_rd0_wr1 ? i_wr_data : '0;
      end
   end

   always_comb begin
      state_d        = state_q;
      rsp_fifo_rd_en = 1'b0;
      stale_drop     = 1'b0;
      unique case (state_q)
         StNormal: begin
            stale_drop = stale_pending && !rsp_fifo_empty;
            if (sleep_pending) begin
               state_d = StDrain;
            end else if (req_fifo_wr_en && !i_rd0_wr1) begin
               state_d = StWaitRsp;
            end
         end
         StWaitRsp: begin
            // Invalid entries are popped and dropped while the read stays outstanding.
            rsp_fifo_rd_en = !rsp_fifo_empty;
            if (rsp_done || timeout) begin
               state_d = StNormal;
            end
         end
         StDrain: begin
            stale_drop = stale_pending && !rsp_fifo_empty;
            if (req_fifo_empty && rsp_fifo_empty) begin
               state_d = StSleep;
            end
         end
         StSleep: begin
            if (!sleep_pending) begin
               state_d = StNormal;
            end
         end
         default: state_d = StNormal;
      endcase
      if (stale_drop) begin
         rsp_fifo_rd_en = 1'b1;
      end
   end

   always_ff @(posedge i_clk_source or negedge i_rstn_source) begin
      if (!i_rstn_source) begin
         state_q    <= StNormal;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= rsp_done || timeout;
         rd_err_q   <= timeout;
         if (rsp_done) begin
            rd_data_q <= i_packet[DATA_WIDTH-1:0];
         end else if (timeout) begin
            rd_data_q <= '0;
         end
      end
   end

   assign o_rd_valid          = rd_valid_q;
   assign o_rd_err            = rd_err_q;
   assign o_rd_data           = rd_data_q;
   assign source_sleep_status = (state_q == StDrain) || (state_q == StSleep);
   assign o_source_sleep_ack  = (state_q == StSleep) && i_source_sleep_req;

`ifdef SOURCE_RSP_TIMEOUT_EN
   source_rsp_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rsp_timer (
      .clk          (i_clk_source),
      .rst_n        (i_rstn_source),
      .waiting      (state_q == StWaitRsp),
      .rsp_done     (rsp_done),
      .stale_drop   (stale_drop),
      .timeout      (timeout),
      .stale_pending(stale_pending)
   );
`else
   logic unused_timeout_cfg;
   assign timeout            = 1'b0;
   assign stale_pending      = 1'b0;
   assign unused_timeout_cfg = stale_drop ^ (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_source_controller.sv
// Self-checking bench for source_controller; the timeout scenario runs when
// SOURCE_RSP_TIMEOUT_EN is defined.
module tb_source_controller;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned PW = 66;
   localparam int unsigned TO = 16;

   logic          i_clk_source = 1'b0;
   logic          i_rstn_source = 1'b1;
   logic          i_source_sleep_req, sink_sleep_status, i_valid, i_rd0_wr1;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_wr_data;
   logic          o_ready;
   logic [DW-1:0] o_rd_data;
   logic          o_rd_valid, o_rd_err;
   logic          req_fifo_full, req_fifo_empty, req_fifo_wr_en;
   logic [PW-1:0] o_packet;
   logic          rsp_fifo_empty;
   logic [DW:0]   i_packet;
   logic          rsp_fifo_rd_en, o_source_sleep_ack, source_sleep_status;

   int errors = 0;
   int checks = 0;

   always #5 i_clk_source = ~i_clk_source;

   source_controller #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .PACKET_WIDTH  (PW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk_source       (i_clk_source),
      .i_rstn_source      (i_rstn_source),
      .i_source_sleep_req (i_source_sleep_req),
      .sink_sleep_status  (sink_sleep_status),
      .i_valid            (i_valid),
      .i_rd0_wr1          (i_rd0_wr1),
      .i_addr             (i_addr),
      .i_wr_data          (i_wr_data),
      .o_ready            (o_ready),
      .o_rd_data          (o_rd_data),
      .o_rd_valid         (o_rd_valid),
      .o_rd_err           (o_rd_err),
      .req_fifo_full      (req_fifo_full),
      .req_fifo_empty     (req_fifo_empty),
      .req_fifo_wr_en     (req_fifo_wr_en),
      .o_packet           (o_packet),
      .rsp_fifo_empty     (rsp_fifo_empty),
      .i_packet           (i_packet),
      .rsp_fifo_rd_en     (rsp_fifo_rd_en),
      .o_source_sleep_ack (o_source_sleep_ack),
      .source_sleep_status(source_sleep_status)
   );

   task automatic tick();
      @(posedge i_clk_source);
      #1;
   endtask

   task automatic sample();
      @(negedge i_clk_source);
   endtask

   task automatic idle();
      i_valid            = 1'b0;
      i_rd0_wr1          = 1'b0;
      i_addr             = '0;
      i_wr_data          = '0;
      i_source_sleep_req = 1'b0;
      sink_sleep_status  = 1'b0;
      req_fifo_full      = 1'b0;
      req_fifo_empty     = 1'b1;
      rsp_fifo_empty     = 1'b1;
      i_packet           = '0;
   endtask

   task automatic test_reset();
      logic [104:0] outs;
      idle();
      i_valid   = 1'b1;
      i_rd0_wr1 = 1'b1;
      i_addr    = 32'h1234;
      i_wr_data = 32'h5678;
      #1 i_rstn_source = 1'b0;
      repeat (2) sample();
      outs = {o_ready, req_fifo_wr_en, rsp_fifo_rd_en, o_rd_valid, o_rd_err, o_source_sleep_ack,
              source_sleep_status, o_rd_data, o_packet};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", outs);
      end
      i_valid = 1'b0;
      tick();
      i_rstn_source = 1'b1;
      sample();
      checks++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", o_ready);
      end
      checks++;
      if (source_sleep_status !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_status: got %b want 0", source_sleep_status);
      end
      tick();
   endtask

   task automatic test_write();
      logic exp_push;
      idle();
      i_valid   = 1'b1;
      i_rd0_wr1 = 1'b1;
      i_addr    = 32'h1000_0004;
      i_wr_data = 32'hA5A5_0001;
      sample();
      checks++;
      if (req_fifo_wr_en !== 1'b1) begin
         errors++;
         $display("FAIL write_push: got %b want 1", req_fifo_wr_en);
      end
      checks++;
      if (o_packet !== 66'h3_1000_0004_A5A5_0001) begin
         errors++;
         $display("FAIL write_packet: got %h want %h", o_packet, 66'h3_1000_0004_A5A5_0001);
      end
      tick();
      sample();
      checks++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL write_ready_after: got %b want 1", o_ready);
      end
      tick();
      // Random posted writes against a full flag; reads offered only while full must not be taken.
      for (int i = 0; i < 40; i++) begin
         req_fifo_full = ($urandom_range(0, 3) == 0);
         i_valid       = 1'($urandom_range(0, 1));
         i_rd0_wr1     = req_fifo_full ? 1'($urandom_range(0, 1)) : 1'b1;
         i_addr        = $urandom;
         i_wr_data     = $urandom;
         exp_push      = i_valid && !req_fifo_full;
         sample();
         checks++;
         if (o_ready !== !req_fifo_full) begin
            errors++;
            $display("FAIL wr_rand_ready[%0d]: got %b want %b", i, o_ready, !req_fifo_full);
         end
         checks++;
         if (req_fifo_wr_en !== exp_push) begin
            errors++;
            $display("FAIL wr_rand_push[%0d]: got %b want %b", i, req_fifo_wr_en, exp_push);
         end
         if (exp_push) begin
            checks++;
            if (o_packet !== {2'b11, i_addr, i_wr_data}) begin
               errors++;
               $display("FAIL wr_rand_packet[%0d]: got %h want %h", i, o_packet,
                        {2'b11, i_addr, i_wr_data});
            end
         end
         tick();
      end
      idle();
      tick();
   endtask

   task automatic test_backpressure();
      idle();
      i_valid       = 1'b1;
      i_rd0_wr1     = 1'b1;
      i_addr        = 32'h44;
      i_wr_data     = 32'h55;
      req_fifo_full = 1'b1;
      sample();
      checks++;
      if (o_ready !== 1'b0 || req_fifo_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL bp_full: got ready=%b push=%b want 0 0", o_ready, req_fifo_wr_en);
      end
      req_fifo_full = 1'b0;
      #1;
      checks++;
      if (o_ready !== 1'b1 || req_fifo_wr_en !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got ready=%b push=%b want 1 1", o_ready, req_fifo_wr_en);
      end
      checks++;
      if (o_packet !== {2'b11, 32'h44, 32'h55}) begin
         errors++;
         $display("FAIL bp_packet: got %h want %h", o_packet, {2'b11, 32'h44, 32'h55});
      end
      tick();
      idle();
      tick();
   endtask

   // Response becomes available 'delay' cycles after the FSM starts waiting and is preceded
   // by 'ninv' invalid entries; each entry takes one pop, completion follows the valid pop.
   task automatic do_read(input logic [31:0] addr, input int delay, input int ninv,
                          input logic [31:0] data, input string tag);
      int          pops;
      int          seen_at;
      logic [31:0] junk;
      junk      = $urandom;
      i_valid   = 1'b1;
      i_rd0_wr1 = 1'b0;
      i_addr    = addr;
      i_wr_data = $urandom;
      sample();
      checks++;
      if (req_fifo_wr_en !== 1'b1 || o_packet !== {2'b01, addr, 32'h0}) begin
         errors++;
         $display("FAIL %s_accept: got push=%b pkt=%h want 1 %h", tag, req_fifo_wr_en, o_packet,
                  {2'b01, addr, 32'h0});
      end
      tick();
      i_valid = 1'b0;
      pops    = 0;
      seen_at = -1;
      for (int cyc = 1; cyc <= delay + ninv + 10 && seen_at < 0; cyc++) begin
         rsp_fifo_empty = !(cyc > delay && pops <= ninv);
         i_packet       = (pops < ninv) ? {1'b0, junk ^ 32'(pops)} : {1'b1, data};
         sample();
         if (o_rd_valid === 1'b1) begin
            seen_at = cyc;
            checks++;
            if (o_rd_data !== data || o_rd_err !== 1'b0) begin
               errors++;
               $display("FAIL %s_data: got %h err=%b want %h err=0", tag, o_rd_data, o_rd_err,
                        data);
            end
         end
         checks++;
         if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_wait[%0d]: got %b want 0", tag, cyc, o_ready);
         end
         if (rsp_fifo_rd_en === 1'b1) begin
            checks++;
            if (rsp_fifo_empty !== 1'b0) begin
               errors++;
               $display("FAIL %s_pop_empty[%0d]: got pop=1 want 0", tag, cyc);
            end
            pops++;
         end
         tick();
      end
      rsp_fifo_empty = 1'b1;
      checks++;
      if (seen_at != delay + ninv + 2) begin
         errors++;
         $display("FAIL %s_latency: got %0d want %0d", tag, seen_at, delay + ninv + 2);
      end
      checks++;
      if (pops != ninv + 1) begin
         errors++;
         $display("FAIL %s_pops: got %0d want %0d", tag, pops, ninv + 1);
      end
      sample();
      checks++;
      if (o_rd_valid !== 1'b0 || o_ready !== 1'b1 || o_rd_data !== data) begin
         errors++;
         $display("FAIL %s_after: got valid=%b ready=%b data=%h want 0 1 %h", tag, o_rd_valid,
                  o_ready, o_rd_data, data);
      end
      tick();
   endtask

   task automatic test_read();
      idle();
      do_read(32'h20, 2, 0, 32'hCAFE_F00D, "rd_dir");
      for (int i = 0; i < 10; i++) begin
         do_read($urandom, $urandom_range(0, 4), $urandom_range(0, 2), $urandom, "rd_rand");
      end
   endtask

   task automatic test_sleep();
      idle();
      req_fifo_empty     = 1'b0;
      rsp_fifo_empty     = 1'b0;
      i_packet           = {1'b1, 32'hDEAD_BEEF};
      i_source_sleep_req = 1'b1;
      i_valid            = 1'b1;
      i_rd0_wr1          = 1'b0;
      i_addr             = 32'h80;
      sample();
      checks++;
      if (o_ready !== 1'b0 || req_fifo_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL slp_no_accept: got ready=%b push=%b want 0 0", o_ready, req_fifo_wr_en);
      end
      tick();
      i_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         checks++;
         if (source_sleep_status !== 1'b1 || o_source_sleep_ack !== 1'b0
             || rsp_fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL slp_drain[%0d]: got st=%b ack=%b pop=%b want 1 0 0", i,
                     source_sleep_status, o_source_sleep_ack, rsp_fifo_rd_en);
         end
         tick();
      end
      req_fifo_empty = 1'b1;
      rsp_fifo_empty = 1'b1;
      sample();
      checks++;
      if (o_source_sleep_ack !== 1'b0) begin
         errors++;
         $display("FAIL slp_ack_early: got %b want 0", o_source_sleep_ack);
      end
      tick();
      sample();
      checks++;
      if (o_source_sleep_ack !== 1'b1 || source_sleep_status !== 1'b1) begin
         errors++;
         $display("FAIL slp_ack: got ack=%b st=%b want 1 1", o_source_sleep_ack,
                  source_sleep_status);
      end
      i_source_sleep_req = 1'b0;
      #1;
      checks++;
      if (o_source_sleep_ack !== 1'b0) begin
         errors++;
         $display("FAIL slp_ack_drop: got %b want 0", o_source_sleep_ack);
      end
      tick();
      sample();
      checks++;
      if (source_sleep_status !== 1'b0 || o_ready !== 1'b1) begin
         errors++;
         $display("FAIL slp_wake: got st=%b ready=%b want 0 1", source_sleep_status, o_ready);
      end
      tick();
      // Sink-initiated drain whose request is withdrawn before the FIFOs empty.
      req_fifo_empty    = 1'b0;
      sink_sleep_status = 1'b1;
      sample();
      checks++;
      if (o_ready !== 1'b0) begin
         errors++;
         $display("FAIL slp_sink_ready: got %b want 0", o_ready);
      end
      tick();
      sink_sleep_status = 1'b0;
      sample();
      checks++;
      if (source_sleep_status !== 1'b1 || o_ready !== 1'b0) begin
         errors++;
         $display("FAIL slp_drain_hold: got st=%b ready=%b want 1 0", source_sleep_status, o_ready);
      end
      tick();
      sample();
      req_fifo_empty = 1'b1;
      tick();
      sample();
      checks++;
      if (source_sleep_status !== 1'b1 || o_source_sleep_ack !== 1'b0 || o_ready !== 1'b0) begin
         errors++;
         $display("FAIL slp_brief: got st=%b ack=%b ready=%b want 1 0 0", source_sleep_status,
                  o_source_sleep_ack, o_ready);
      end
      tick();
      sample();
      checks++;
      if (source_sleep_status !== 1'b0 || o_ready !== 1'b1) begin
         errors++;
         $display("FAIL slp_exit: got st=%b ready=%b want 0 1", source_sleep_status, o_ready);
      end
      tick();
      idle();
   endtask

   task automatic test_reset_mid();
      logic [104:0] outs;
      idle();
      i_valid   = 1'b1;
      i_rd0_wr1 = 1'b0;
      i_addr    = 32'h300;
      sample();
      checks++;
      if (req_fifo_wr_en !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_accept: got %b want 1", req_fifo_wr_en);
      end
      tick();
      i_valid = 1'b0;
      tick();
      rsp_fifo_empty = 1'b0;
      i_packet       = {1'b1, 32'h7777_8888};
      i_rstn_source  = 1'b0;
      #1;
      outs = {o_ready, req_fifo_wr_en, rsp_fifo_rd_en, o_rd_valid, o_rd_err, o_source_sleep_ack,
              source_sleep_status, o_rd_data, o_packet};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs: got %h want 0", outs);
      end
      tick();
      tick();
      i_rstn_source = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sample();
         checks++;
         if (o_rd_valid !== 1'b0 || rsp_fifo_rd_en !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after[%0d]: got valid=%b pop=%b ready=%b want 0 0 1", i,
                     o_rd_valid, rsp_fifo_rd_en, o_ready);
         end
         tick();
      end
      idle();
   endtask

`ifdef SOURCE_RSP_TIMEOUT_EN
   task automatic test_timeout();
      int seen_at;
      seen_at   = -1;
      idle();
      i_valid   = 1'b1;
      i_rd0_wr1 = 1'b0;
      i_addr    = 32'h900;
      sample();
      checks++;
      if (req_fifo_wr_en !== 1'b1) begin
         errors++;
         $display("FAIL to_accept: got %b want 1", req_fifo_wr_en);
      end
      tick();
      i_valid = 1'b0;
      for (int cyc = 1; cyc <= int'(TO) + 4 && seen_at < 0; cyc++) begin
         sample();
         if (o_rd_valid === 1'b1) begin
            seen_at = cyc;
            checks++;
            if (o_rd_err !== 1'b1 || o_rd_data !== 32'h0) begin
               errors++;
               $display("FAIL to_err: got err=%b data=%h want 1 0", o_rd_err, o_rd_data);
            end
         end
         checks++;
         if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL to_ready_wait[%0d]: got %b want 0", cyc, o_ready);
         end
         tick();
      end
      checks++;
      if (seen_at != int'(TO) + 1) begin
         errors++;
         $display("FAIL to_latency: got %0d want %0d", seen_at, TO + 1);
      end
      sample();
      checks++;
      if (o_rd_valid !== 1'b0 || o_ready !== 1'b0) begin
         errors++;
         $display("FAIL to_stale_block: got valid=%b ready=%b want 0 0", o_rd_valid, o_ready);
      end
      tick();
      rsp_fifo_empty = 1'b0;
      i_packet       = {1'b1, 32'h0BAD_0BAD};
      sample();
      checks++;
      if (rsp_fifo_rd_en !== 1'b1) begin
         errors++;
         $display("FAIL to_late_pop: got %b want 1", rsp_fifo_rd_en);
      end
      tick();
      rsp_fifo_empty = 1'b1;
      sample();
      checks++;
      if (o_rd_valid !== 1'b0 || o_ready !== 1'b1) begin
         errors++;
         $display("FAIL to_late_drop: got valid=%b ready=%b want 0 1", o_rd_valid, o_ready);
      end
      tick();
      idle();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      idle();
      test_reset();
      test_write();
      test_backpressure();
      test_read();
`ifdef SOURCE_RSP_TIMEOUT_EN
      test_timeout();
`endif
      test_sleep();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
